// File: rtl/fft_mem_pkg.sv
// Shared defaults and types for the FFT sample-memory reader.
package fft_mem_pkg;

  localparam int NUM_BITS  = 10;
  localparam int ADDR_W    = 11;
  localparam int FRAME_LEN = 2048;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    FIN
  } state_t;

  typedef logic [NUM_BITS-1:0] sample_t;
  typedef logic [ADDR_W-1:0]   addr_t;

endpackage

// File: rtl/fft_rd_skid_fifo.sv
// Two-entry synchronous FIFO that holds {last, data} words between the RAM
// read port and the output stream. The reader's credit logic keeps it from
// ever being pushed while full, but a push into a full FIFO with no pop is
// dropped rather than corrupting an entry.
module fft_rd_skid_fifo #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic [1:0]   count,
  output logic         empty
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign do_pop   = pop & (count_q != 2'd0);
  assign do_push  = push & ((count_q != 2'd2) | do_pop);
  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign empty    = (count_q == 2'd0);

  // Storage, pointers and occupancy; push and pop in the same cycle keep the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fft_frame_reader.sv
// Reads one frame of FRAME_LEN consecutive samples from the single-port
// sample RAM (1-cycle read latency) and streams them to the FFT core.
//
// Output handshake: a sample transfers on every clock edge where s_valid
// and s_ready are both high; once s_valid is raised it stays high with
// s_data/s_last unchanged until that transfer happens.
//
// Reads are issued on credit: a read is only launched when the buffer
// occupancy plus the read still in flight (minus a pop this cycle) leaves
// room, so returning RAM data always has a slot waiting for it.
module fft_frame_reader
  import fft_mem_pkg::*;
#(
  parameter int NUM_BITS  = fft_mem_pkg::NUM_BITS,
  parameter int ADDR_W    = fft_mem_pkg::ADDR_W,
  parameter int FRAME_LEN = fft_mem_pkg::FRAME_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  output logic                busy,
  output logic                done,
  output logic                mem_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [NUM_BITS-1:0] mem_data,
  output logic [NUM_BITS-1:0] s_data,
  output logic                s_valid,
  input  logic                s_ready,
  output logic                s_last,
  output state_t              dbg_state
);

  localparam int               CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_LEN - 1);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [CNT_W-1:0]   issued_q, issued_d;
  logic [CNT_W-1:0]   delivered_q, delivered_d;
  logic               inflight_q;
  logic               inflight_last_q;

  logic               pop;
  logic               credit_ok;
  logic               issue_last;
  logic [1:0]         buf_count;
  logic               buf_empty;
  logic [NUM_BITS:0]  buf_word;

  assign pop        = s_valid & s_ready;
  assign s_valid    = ~buf_empty;
  assign s_last     = buf_word[NUM_BITS];
  assign s_data     = buf_word[NUM_BITS-1:0];
  assign mem_addr   = base_q + issued_q[ADDR_W-1:0];
  assign issue_last = (issued_q == LAST_IDX);
  assign dbg_state  = state_q;

  // Room for another read: buffered + in flight - popped must stay below 2.
  assign credit_ok = ({1'b0, buf_count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

  // Next-state, counters and control outputs.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    issued_d    = issued_q;
    delivered_d = delivered_q;
    mem_en      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    if (pop) begin
      delivered_d = delivered_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = READ;
          base_d      = base_addr;
          issued_d    = '0;
          delivered_d = '0;
        end
      end
      READ: begin
        busy = 1'b1;
        if (issued_q < FRAME_CNT) begin
          if (credit_ok) begin
            mem_en   = 1'b1;
            issued_d = issued_q + 1'b1;
          end
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (pop && (delivered_q == LAST_IDX)) begin
          state_d = FIN;
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and the read-in-flight tracker (tags the frame's last read).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      base_q          <= '0;
      issued_q        <= '0;
      delivered_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      base_q          <= base_d;
      issued_q        <= issued_d;
      delivered_q     <= delivered_d;
      inflight_q      <= mem_en;
      inflight_last_q <= mem_en & issue_last;
    end
  end

  fft_rd_skid_fifo #(
    .W(NUM_BITS + 1)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data ({inflight_last_q, mem_data}),
    .pop       (pop),
    .pop_data  (buf_word),
    .count     (buf_count),
    .empty     (buf_empty)
  );

endmodule

// File: tb/tb_fft_frame_reader.sv
// Directed bench for fft_frame_reader: four instances with different frame
// lengths (8, 16, 4, 1) share one clock and reset; one is exercised at a time.
module tb_fft_frame_reader;
  import fft_mem_pkg::*;

  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT wiring ----------------
  logic         start_a [N];
  logic [10:0]  base_a  [N];
  logic         busy_a  [N];
  logic         done_a  [N];
  logic         en_a    [N];
  logic [10:0]  addr_a  [N];
  logic [9:0]   rdata_a [N];
  logic [9:0]   sdata_a [N];
  logic         valid_a [N];
  logic         ready_a [N];
  logic         last_a  [N];
  state_t       dbg_a   [N];

  int           cur   = 0;
  logic         start = 1'b0;
  logic         ready = 1'b1;
  logic [10:0]  base  = '0;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      start_a[k] = start && (cur == k);
      base_a[k]  = base;
      ready_a[k] = (cur == k) ? ready : 1'b1;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int FL = (g == 0) ? 8 : (g == 1) ? 16 : (g == 2) ? 4 : 1;
    fft_frame_reader #(
      .NUM_BITS (10),
      .ADDR_W   (11),
      .FRAME_LEN(FL)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start_a[g]),
      .base_addr(base_a[g]),
      .busy     (busy_a[g]),
      .done     (done_a[g]),
      .mem_en   (en_a[g]),
      .mem_addr (addr_a[g]),
      .mem_data (rdata_a[g]),
      .s_data   (sdata_a[g]),
      .s_valid  (valid_a[g]),
      .s_ready  (ready_a[g]),
      .s_last   (last_a[g]),
      .dbg_state(dbg_a[g])
    );
  end

  // RAM model: 1-cycle read latency, RAM[a] = a[9:0].
  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (en_a[k]) rdata_a[k] <= addr_a[k][9:0];
    end
  end

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit mon_on = 1'b0;

  logic [10:0] addr_q[$];
  logic [9:0]  data_q[$];
  logic [9:0]  exp_q[$];
  int          last_idx_q[$];
  int first_en, last_en, first_valid, last_hs, done_cnt, done_cyc, start_cyc;
  int occ;
  bit prev_en, prev_stall;
  logic [9:0] prev_data;
  logic prev_last;
  bit pat6 [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic mon_reset();
    addr_q.delete();
    data_q.delete();
    last_idx_q.delete();
    first_en = -1; last_en = -1; first_valid = -1; last_hs = -1;
    done_cnt = 0; done_cyc = -1;
    occ = 0; prev_en = 1'b0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    mon_on = 1'b1;
  endtask

  // One clock cycle: sample at the falling edge, return just after the rising edge.
  task automatic tick();
    logic en, v, r, l, dn, pop;
    logic [10:0] a;
    logic [9:0] d;
    @(negedge clk);
    cyc++;
    en = en_a[cur]; a = addr_a[cur]; v = valid_a[cur]; r = ready_a[cur];
    d = sdata_a[cur]; l = last_a[cur]; dn = done_a[cur];
    pop = v & r;
    if (mon_on) begin
      if (en) begin
        chk("credit", ((occ + int'(prev_en) - int'(pop)) < 2), 1);
        addr_q.push_back(a);
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
      end
      chk("valid_vs_buffer", v, (occ > 0));
      if (prev_stall) begin
        chk("stall_valid", v, 1);
        chk("stall_data", d, prev_data);
        chk("stall_last", l, prev_last);
      end
      if (v && first_valid < 0) first_valid = cyc;
      if (pop) begin
        data_q.push_back(d);
        if (l) begin
          last_idx_q.push_back(data_q.size() - 1);
          last_hs = cyc;
        end
      end
      if (dn) begin
        done_cnt++;
        done_cyc = cyc;
      end
      occ = occ + int'(prev_en) - int'(pop);
      prev_en = en;
      prev_stall = v & ~r;
      prev_data = d;
      prev_last = l;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_frame(input int inst, input logic [10:0] b);
    cur = inst;
    base = b;
    mon_reset();
    ready = 1'b1;
    start = 1'b1;
    tick();
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic finish_frame(input int mode, input int max_cyc);
    for (int k = 0; k < max_cyc && done_cnt == 0; k++) begin
      ready = (mode == 0) ? 1'b1 : pat6[k % 6];
      tick();
    end
    chk("done_seen", (done_cnt > 0), 1);
    ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic frame_check(input int fl, input logic [10:0] b);
    logic [10:0] a;
    exp_q.delete();
    for (int i = 0; i < fl; i++) begin
      a = b + 11'(i);
      exp_q.push_back(a[9:0]);
    end
    chk("n_addr", addr_q.size(), fl);
    chk("n_data", data_q.size(), fl);
    for (int i = 0; i < fl && i < addr_q.size(); i++) begin
      a = b + 11'(i);
      chk("addr", addr_q[i], a);
    end
    for (int i = 0; i < data_q.size() && exp_q.size() > 0; i++) begin
      chk("data", data_q[i], exp_q.pop_front());
    end
    chk("n_last", last_idx_q.size(), 1);
    if (last_idx_q.size() > 0) chk("last_idx", last_idx_q[0], fl - 1);
    chk("n_done", done_cnt, 1);
    chk("done_after_last", done_cyc, last_hs + 1);
  endtask

  task automatic chk_reset_outputs(input int k, input string tag);
    chk({tag, "_busy"},  busy_a[k],  0);
    chk({tag, "_done"},  done_a[k],  0);
    chk({tag, "_en"},    en_a[k],    0);
    chk({tag, "_addr"},  addr_a[k],  0);
    chk({tag, "_valid"}, valid_a[k], 0);
    chk({tag, "_last"},  last_a[k],  0);
    chk({tag, "_data"},  sdata_a[k], 0);
    chk({tag, "_state"}, dbg_a[k],   IDLE);
  endtask

  // Watchdog: the directed sequence is a few hundred cycles.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < N; k++) chk_reset_outputs(k, "reset");
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // 1: FRAME_LEN=8, base 0, ready held high.
    start_frame(0, 11'd0);
    finish_frame(0, 40);
    frame_check(8, 11'd0);
    chk("t1_first_en", first_en, start_cyc + 1);
    chk("t1_en_span", last_en - first_en, 7);
    chk("t1_first_valid", first_valid, first_en + 2);
    chk("t1_data_span", last_hs - first_valid, 7);
    chk("t1_frame_time", done_cyc, start_cyc + 11);
    chk("t1_idle_busy", busy_a[0], 0);

    // 2: address wrap, FRAME_LEN=4, base 2046.
    start_frame(2, 11'd2046);
    finish_frame(0, 40);
    frame_check(4, 11'd2046);
    chk("t2_addr1", addr_q[1], 2047);
    chk("t2_addr2", addr_q[2], 0);
    chk("t2_data0", data_q[0], 1022);
    chk("t2_data1", data_q[1], 1023);
    chk("t2_data3", data_q[3], 1);
    chk("t2_frame_time", done_cyc, start_cyc + 7);

    // 3: ready toggling 1,0,0,1,0,1..., FRAME_LEN=16.
    start_frame(1, 11'd300);
    finish_frame(1, 200);
    frame_check(16, 11'd300);

    // 4: ready low for 20 cycles after start.
    start_frame(1, 11'd100);
    ready = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    chk("t4_reads_issued", addr_q.size(), 2);
    chk("t4_valid_held", valid_a[1], 1);
    chk("t4_data_held", sdata_a[1], 100);
    chk("t4_last_low", last_a[1], 0);
    chk("t4_no_handshake", data_q.size(), 0);
    finish_frame(0, 60);
    frame_check(16, 11'd100);

    // 5: start pulsed mid-frame and during FIN, FRAME_LEN=8.
    start_frame(0, 11'd500);
    for (int k = 0; k < 30; k++) begin
      start = (cyc + 1 == start_cyc + 4) || (cyc + 1 == start_cyc + 11);
      base = start ? 11'd7 : 11'd500;
      ready = 1'b1;
      tick();
    end
    start = 1'b0;
    frame_check(8, 11'd500);
    chk("t5_fin_cycle", done_cyc, start_cyc + 11);
    chk("t5_busy_after", busy_a[0], 0);
    chk("t5_state_after", dbg_a[0], IDLE);

    // 6: reset mid-frame at the fifth delivered sample, then a clean frame.
    start_frame(1, 11'd0);
    for (int k = 0; k < 40 && data_q.size() < 5; k++) tick();
    chk("t6_reached_5", data_q.size(), 5);
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs(1, "t6_async");
    chk("t6_no_done", done_cnt, 0);
    mon_on = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    chk("t6_idle_after", dbg_a[1], IDLE);
    start_frame(1, 11'd1000);
    finish_frame(0, 60);
    frame_check(16, 11'd1000);

    // FRAME_LEN=1: single sample carries s_last.
    start_frame(3, 11'd9);
    finish_frame(0, 20);
    frame_check(1, 11'd9);
    chk("fl1_data", data_q[0], 9);
    chk("fl1_frame_time", done_cyc, start_cyc + 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fft_frame_reader.md
Name: fft_frame_reader

Overview:
- Reader side of the FFT sample memory: on command, fetches one frame of FRAME_LEN consecutive samples over the single-port RAM read interface (1-cycle read latency) and streams them out on a valid/ready interface to the FFT core.
- Absorbs read latency and downstream backpressure with a 2-entry output buffer. Sustains 1 sample/cycle while s_ready stays high.
- Owns the RAM port only while busy; port arbitration with the capture writer lives outside this block.

Parameters:
- NUM_BITS, 10, sample width in bits.
- ADDR_W, 11, RAM address width.
- FRAME_LEN, 2048, samples per frame; legal range 1..2**ADDR_W.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  frame request pulse; accepted only in IDLE.
- base_addr  in  ADDR_W  first sample address; captured when start is accepted.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse, frame complete.
- mem_en  out  1  read enable to RAM (we is tied 0 outside).
- mem_addr  out  ADDR_W  RAM address.
- mem_data  in  NUM_BITS  RAM read data, valid one cycle after mem_en.
- s_data  out  NUM_BITS  sample.
- s_valid  out  1  sample valid.
- s_ready  in  1  consumer ready.
- s_last  out  1  marks the final sample of the frame.

Behaviour:
- Reset (async assert, sync release): state IDLE, busy=0, done=0, mem_en=0, mem_addr=0, s_valid=0, s_last=0, s_data=0, buffer empty, all counters 0.
- States:
  - IDLE: start -> READ; latch base_addr and clear issue/deliver counters.
  - READ: issue reads until FRAME_LEN reads have been issued -> DRAIN.
  - DRAIN: wait until FRAME_LEN samples have been delivered -> FIN.
  - FIN: done=1 for one cycle, busy=0 -> IDLE.
- busy=1 in READ and DRAIN.
- start while busy or in FIN is ignored. No queuing.
- Read issue rule (credit): mem_en=1 in a cycle iff in READ, issued < FRAME_LEN, and (buf_count + inflight - pop) < 2.
  - pop = s_valid & s_ready in that cycle.
  - inflight = mem_en registered from the previous cycle.
  - The 2-entry buffer never overflows, and mem_data is never dropped.
- mem_addr = (base + issued) mod 2**ADDR_W, so addresses wrap past the top of the RAM.
- mem_data is written into the buffer on the edge after the cycle in which mem_en was high.
- Latency: start sampled high at edge T -> mem_en high in cycle T+1 -> buffer write at edge T+2 -> s_valid=1 in cycle T+2..T+3.
  - Required: first s_valid exactly 2 cycles after the first mem_en cycle.
- Output handshake:
  - s_data and s_last hold stable while s_valid=1 and s_ready=0.
  - s_valid never drops without a handshake.
  - Sample order equals address order.
- s_last=1 only with the sample at index FRAME_LEN-1. For FRAME_LEN=1, the first sample carries s_last.
- done pulses in the cycle after the handshake of the s_last sample.
- Throughput: with s_ready held at 1, samples are delivered on consecutive cycles. Total frame time = FRAME_LEN + 3 cycles from start to done.
- Backpressure: when s_ready=0, at most 2 samples are buffered and mem_en stops. Issue resumes in the same cycle a pop frees credit.
- Simultaneous buffer write and pop: the count is unchanged and FIFO order is preserved.
- Reset mid-frame: everything returns to reset values immediately. Partial frame discarded, no done.
- Counters are ADDR_W+1 bits wide so that FRAME_LEN = 2**ADDR_W is representable.

Decomposition:
- Package fft_mem_pkg holds:
  - NUM_BITS, ADDR_W, FRAME_LEN defaults.
  - State typedef enum {IDLE, READ, DRAIN, FIN}.
  - sample_t (logic [NUM_BITS-1:0]) and addr_t typedefs.
- One sub-module: fft_rd_skid_fifo.
  - 2-entry synchronous FIFO carrying {last, data}.
  - Ports: push, push_data, pop, pop_data, count, empty.
- Top-level block holds the FSM, counters, credit logic and address generation.

Test Plan:
1. FRAME_LEN=8, base_addr=0, RAM[i]=i, s_ready=1 -> mem_addr 0..7 on 8 consecutive cycles; s_data 0..7 on consecutive cycles; s_last only with data 7; done exactly 1 cycle after the last handshake; first s_valid 2 cycles after the first mem_en.
2. base_addr=2046, FRAME_LEN=4, RAM[a]=a[9:0] -> addresses 2046, 2047, 0, 1; s_data 1022, 1023, 0, 1.
3. s_ready toggling 1,0,0,1,0,1… with FRAME_LEN=16 -> no sample lost or duplicated; s_data stable while stalled; mem_en never high while buf_count+inflight-pop ≥ 2; checked by a scoreboard.
4. s_ready=0 for 20 cycles after start -> exactly 2 reads issued; s_valid=1 holding sample 0; on release the frame completes in order.
5. start pulsed again mid-frame and during FIN -> ignored; exactly one done; addresses unchanged.
6. rst asserted at delivered sample 5 of 16 -> outputs reach reset values asynchronously; no done; a new start afterward produces a complete, correct frame. Also FRAME_LEN=1 -> single sample with s_last=1, done follows.
